ct_f_spsram_req_ctrl: RTL and testbench
=======================================

# ct_f_spsram_req_ctrl

Request/response controller sitting directly upstream of the `ct_f_spsram_256x100` FPGA single-port SRAM wrapper. It accepts read and write requests over a valid/ready handshake and drives the SRAM's active-low `A`/`CEN`/`GWEN`/`WEN`/`D` pins. It captures `Q` one cycle after each read into a 2-entry response FIFO, which makes response back-pressure lossless. An optional post-reset sweep zero-fills the whole array.

## Interface
- `ADDR_WIDTH`, 8: SRAM address width; the array depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 100: data width.
- `WRAP_SIZE`, 25: lane width. The byte-mask granularity is DATA_WIDTH/WRAP_SIZE = 4 lanes.

Ports:
- `CLK` in 1: single clock, shared with the SRAM.
- `RST` in 1: reset, **asynchronous, active-high** (decided).
- `req_vld` in 1: request valid.
- `req_rdy` out 1: request ready.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH: request address.
- `req_wdata` in DATA_WIDTH: write data.
- `req_wmask` in 4: per-lane write enable, 1 = write the lane.
- `rsp_vld` out 1: read data valid.
- `rsp_rdy` in 1: consumer ready.
- `rsp_data` out DATA_WIDTH: read data.
- `init_done` out 1: array usable.
- `A` out ADDR_WIDTH: SRAM address.
- `CEN` out 1: SRAM chip enable, active low.
- `GWEN` out 1: SRAM global write enable, active low.
- `WEN` out DATA_WIDTH: SRAM per-bit write enable, active low.
- `D` out DATA_WIDTH: SRAM write data.
- `Q` in DATA_WIDTH: SRAM read data.

## Operation
- **States:** INIT, RUN. On reset the block enters INIT if the macro is defined, otherwise RUN. INIT→RUN when the sweep counter reaches 2^ADDR_WIDTH-1. RUN is terminal until the next reset.
- **Acceptance:** a request is accepted when `req_vld && req_rdy`.
- **Ready:** `req_rdy = (state==RUN) && (pend + cnt - pop < 2)`.
  - `pend`: 1 if a read was accepted in the previous cycle.
  - `cnt`: FIFO occupancy, 0..2.
  - `pop`: `rsp_vld && rsp_rdy`.
  - The same credit rule gates writes, so the issue order stays simple.
- **Accept cycle:** the block drives `CEN=0` and `A=req_addr`.
  - Write: `GWEN=0`, `D=req_wdata`, and `WEN` lane k bits = all `~req_wmask[k]`. A write with mask 0 still asserts `CEN`, with `GWEN=0` and `WEN` all 1s, and leaves the array unchanged.
  - Read: `GWEN=1`, `WEN` all 1s.
- **Idle cycles (RUN):** `CEN=1`, `GWEN=1`, `WEN` all 1s; `A` and `D` are don't-care and driven with `req_addr`/`req_wdata`.
- **Read return:** the cycle after a read accept, `pend=1` and `Q` is pushed into the FIFO at that clock edge.
- **FIFO:** 2 entries, with read and write pointers that wrap modulo 2.
  - `rsp_vld = cnt!=0`; `rsp_data` = head entry.
  - Push and pop in the same cycle keep `cnt` unchanged.
  - The credit rule guarantees a push never occurs when the FIFO is full.
- **Ordering:** responses return in read-issue order. Write-then-read to the same address in consecutive cycles returns the new data.
- **RST mid-operation:** FIFO and `pend` are cleared, in-flight reads are dropped, and the sweep restarts from 0.

## Timing
- **Reset values:**
  - `req_rdy` 0 (1 immediately after release when the block enters RUN).
  - `CEN` 1 (held at 1 throughout reset, with INIT entered only on release).
  - `GWEN` 1, `WEN` all 1s, `A` 0, `D` 0.
  - `rsp_vld` 0, `rsp_data` 0.
  - `init_done` 0 with the macro, 1 without.
- **Read latency:** accept at cycle T, `rsp_vld`=1 at T+2 with the data.
- **Throughput:** one request per cycle is sustained while `rsp_rdy`=1.
- **Back-pressure:** with `rsp_rdy`=0, at most 2 reads are outstanding; `req_rdy` drops in the cycle after the second read accept.
- **Response stability:** `rsp_data`/`rsp_vld` are stable while `rsp_vld && !rsp_rdy`.
- **Init:** `init_done` asserts the cycle after the last sweep write. `req_rdy` stays 0 until then.

## Configuration
- **`CT_F_SPSRAM_REQ_CTRL_INIT_EN` defined:**
  - After reset, INIT writes zero to addresses 0..2^ADDR_WIDTH-1, one per cycle, with `CEN=0`, `GWEN=0`, `WEN` all 0s, `D=0`, `A` = sweep counter. This takes 256 cycles by default.
  - `init_done` rises the cycle after the last write.
- **Undefined:** no sweep counter; the block starts in RUN; `init_done` is tied to 1; array contents are undefined until written.

## Test plan
- **Init (macro on):** release `RST` → `CEN=0`, `GWEN=0` for exactly 256 cycles with `A` 0..255 and `D=0`. `init_done` and `req_rdy` are 1 at cycle 257. A read of 0x80 returns 0.
- **Masked write:** write 0x3A with all-1s data and mask 4'b0101 over a prior all-0s value. `WEN` lanes 0 and 2 are 0, lanes 1 and 3 are 1. A read of 0x3A returns lanes 0/2 all-ones and lanes 1/3 zero at T+2.
- **Streaming reads:** back-to-back reads of 0..9 with `rsp_rdy`=1. `req_rdy` stays 1 throughout. Responses appear in order on 10 consecutive cycles starting T+2.
- **Back-pressure:** `rsp_rdy`=0 with reads issued every cycle. Exactly 2 are accepted, `req_rdy`=0 and `rsp_data` is held. Raising `rsp_rdy` drains both in order and `req_rdy` reasserts.
- **Write-read hazard:** write 0x10 = X then read 0x10 on the next cycle → the response returns X.
- **Reset mid-operation:** assert `RST` with 2 responses buffered and the sweep at address 100. `rsp_vld`=0 immediately. After release the sweep restarts at `A`=0.

Source files
------------

// File: rtl/ct_f_spsram_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ct_f_spsram_req_ctrl
// Brief    : valid/ready request front-end for the ct_f_spsram_256x100 SRAM,
//            with a 2-entry read-response FIFO. Optional zero-fill sweep after
//            reset when CT_F_SPSRAM_REQ_CTRL_INIT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ct_f_spsram_req_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 100,
  parameter int WRAP_SIZE  = 25
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            req_vld,
  output logic                            req_rdy,
  input  logic                            req_wr,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [DATA_WIDTH-1:0]           req_wdata,
  input  logic [DATA_WIDTH/WRAP_SIZE-1:0] req_wmask,
  output logic                            rsp_vld,
  input  logic                            rsp_rdy,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            init_done,
  output logic [ADDR_WIDTH-1:0]           A,
  output logic                            CEN,
  output logic                            GWEN,
  output logic [DATA_WIDTH-1:0]           WEN,
  output logic [DATA_WIDTH-1:0]           D,
  input  logic [DATA_WIDTH-1:0]           Q
);

  localparam int         c_LANES   = DATA_WIDTH / WRAP_SIZE;
  localparam logic [0:0] c_ST_INIT = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  logic [0:0]            r_state;
  logic                  r_pend;
  logic [1:0]            r_cnt;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [DATA_WIDTH-1:0] r_fifo [2];

  logic                  w_run;
  logic                  w_pop;
  logic                  w_acc;
  logic                  w_sweep;
  logic [ADDR_WIDTH-1:0] w_sweep_addr;
  logic [2:0]            w_credit;
  logic [DATA_WIDTH-1:0] w_lane_wen;

`ifdef CT_F_SPSRAM_REQ_CTRL_INIT_EN
  localparam logic [ADDR_WIDTH-1:0] c_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  logic [ADDR_WIDTH-1:0] r_sweep;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_ST_INIT;
      r_sweep <= '0;
    end else if (r_state == c_ST_INIT) begin
      r_sweep <= r_sweep + c_ONE;
      if (r_sweep == {ADDR_WIDTH{1'b1}}) r_state <= c_ST_RUN;
    end
  end

  assign w_sweep      = (r_state == c_ST_INIT);
  assign w_sweep_addr = r_sweep;
  assign init_done    = (r_state == c_ST_RUN);
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= c_ST_RUN;
    else     r_state <= c_ST_RUN;
  end

  assign w_sweep      = 1'b0;
  assign w_sweep_addr = '0;
  assign init_done    = 1'b1;
`endif

  // Credits cover both the read in flight (pend) and the buffered responses,
  // so a push can never land on a full FIFO.
  assign w_run    = (r_state == c_ST_RUN) && !RST;
  assign rsp_vld  = (r_cnt != 2'd0);
  assign w_pop    = rsp_vld && rsp_rdy;
  assign w_credit = {2'b00, r_pend} + {1'b0, r_cnt} - {2'b00, w_pop};
  assign req_rdy  = w_run && (w_credit < 3'd2);
  assign w_acc    = req_vld && req_rdy;
  assign rsp_data = r_fifo[r_rptr];

  generate
    for (genvar k = 0; k < c_LANES; k++) begin : g_lane
      assign w_lane_wen[k*WRAP_SIZE +: WRAP_SIZE] = {WRAP_SIZE{~req_wmask[k]}};
    end
  endgenerate

  always_comb begin
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    A    = req_addr;
    D    = req_wdata;
    if (RST) begin
      A = '0;
      D = '0;
    end else if (w_sweep) begin
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = '0;
      A    = w_sweep_addr;
      D    = '0;
    end else if (w_acc) begin
      CEN = 1'b0;
      if (req_wr) begin
        GWEN = 1'b0;
        WEN  = w_lane_wen;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend <= 1'b0;
      r_cnt  <= 2'd0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
    end else begin
      r_pend <= w_acc && !req_wr;
      if (r_pend) begin
        r_fifo[r_wptr] <= Q;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({r_pend, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ct_f_spsram_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for ct_f_spsram_req_ctrl: SRAM model, queue-based response model checked
// every cycle, plus directed sequences with literal expectations.
module tb_ct_f_spsram_req_ctrl;
  localparam int AW = 8;
  localparam int DW = 100;
  localparam int WS = 25;
  localparam int NL = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_vld = 1'b0;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NL-1:0] req_wmask = '0;
  logic          rsp_rdy = 1'b1;
  logic          req_rdy, rsp_vld, init_done, CEN, GWEN;
  logic [DW-1:0] rsp_data, WEN, D;
  logic [AW-1:0] A;
  logic [DW-1:0] Q = '0;

  always #5 CLK = ~CLK;

  ct_f_spsram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRAP_SIZE(WS)) dut (
    .CLK(CLK), .RST(RST), .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .init_done(init_done),
    .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
  );

  // Behavioural single-port SRAM: registered read, per-bit active-low write enable.
  logic [DW-1:0] sram [256];
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
      else       Q <= sram[A];
    end
  end

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rdq [$];
  logic [DW-1:0] ref_mem [256];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            since = 0;
  logic          m_vld, m_pop, m_rdy, m_acc, m_init;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
  end

  function automatic logic [DW-1:0] lanes(input logic [NL-1:0] m);
    logic [DW-1:0] r;
    for (int k = 0; k < NL; k++) r[k*WS +: WS] = {WS{m[k]}};
    return r;
  endfunction

  function automatic logic [DW-1:0] pat(input int j);
    logic [WS-1:0] v;
    v = WS'(j * 3 + 1);
    return {v, v, v, v};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Per-cycle model: responses are due two cycles after their read is accepted,
  // and a request may be taken while fewer than two reads remain unconsumed.
  always @(negedge CLK) begin
    if (RST) begin
      rdq.delete();
      cyc   = 0;
      since = 0;
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_CEN", CEN, 1);
      chk("rst_GWEN", GWEN, 1);
      chk("rst_WEN", WEN, {DW{1'b1}});
      chk("rst_A", A, 0);
      chk("rst_D", D, 0);
`ifdef CT_F_SPSRAM_REQ_CTRL_INIT_EN
      chk("rst_init_done", init_done, 0);
`else
      chk("rst_init_done", init_done, 1);
`endif
    end else begin
`ifdef CT_F_SPSRAM_REQ_CTRL_INIT_EN
      m_init = (since < 256);
`else
      m_init = 1'b0;
`endif
      if (m_init) begin
        chk("init_CEN", CEN, 0);
        chk("init_GWEN", GWEN, 0);
        chk("init_WEN", WEN, 0);
        chk("init_A", A, since[7:0]);
        chk("init_D", D, 0);
        chk("init_req_rdy", req_rdy, 0);
        chk("init_done_low", init_done, 0);
        ref_mem[since[7:0]] = '0;
        since++;
      end else begin
        m_vld = (rdq.size() > 0) && (rdq[0].cyc <= cyc - 2);
        m_pop = m_vld && rsp_rdy;
        m_rdy = (rdq.size() - (m_pop ? 1 : 0)) < 2;
        m_acc = req_vld && m_rdy;
        chk("init_done", init_done, 1);
        chk("rsp_vld", rsp_vld, m_vld);
        chk("req_rdy", req_rdy, m_rdy);
        chk("CEN", CEN, !m_acc);
        chk("GWEN", GWEN, !(m_acc && req_wr));
        chk("WEN", WEN, (m_acc && req_wr) ? lanes(~req_wmask) : {DW{1'b1}});
        if (m_acc) chk("A", A, req_addr);
        if (m_acc && req_wr) chk("D", D, req_wdata);
        if (m_vld) chk("rsp_data", rsp_data, rdq[0].data);
        if (m_pop) void'(rdq.pop_front());
        if (m_acc) begin
          if (req_wr)
            ref_mem[req_addr] = (ref_mem[req_addr] & ~lanes(req_wmask)) | (req_wdata & lanes(req_wmask));
          else
            rdq.push_back('{cyc, ref_mem[req_addr]});
        end
        cyc++;
      end
    end
  end

  task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [NL-1:0] mask, output logic [DW-1:0] wen_seen);
    bit ok = 0;
    req_vld   = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = data;
    req_wmask = mask;
    wen_seen  = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (req_rdy) begin
        ok       = 1;
        wen_seen = WEN;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: req_rdy got 0 expected 1 within 20 cycles");
    end
    @(posedge CLK);
    #1;
    req_vld = 1'b0;
  endtask

  task automatic wait_rsp(input string nm, input logic [DW-1:0] exp);
    bit ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (rsp_vld) begin
        ok = 1;
        break;
      end
    end
    if (ok) chk(nm, rsp_data, exp);
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: rsp_vld got 0 expected 1 within 10 cycles", nm);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_init();
    int n_low = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (init_done) break;
      n_low++;
    end
    chk("init_len", n_low, 256);
    chk("init_rdy", req_rdy, 1);
    @(posedge CLK);
    #1;
  endtask

  localparam logic [DW-1:0] X_VAL  = 100'h0123456789ABCDEF012345678;
  localparam logic [DW-1:0] MASKED = {25'h0, 25'h1FFFFFF, 25'h0, 25'h1FFFFFF};
  localparam logic [DW-1:0] WEN_05 = {25'h1FFFFFF, 25'h0, 25'h1FFFFFF, 25'h0};

  initial begin
    logic [DW-1:0] wen;
    int            nacc;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
`ifdef CT_F_SPSRAM_REQ_CTRL_INIT_EN
    wait_init();
    do_req(0, 8'h80, '0, 4'h0, wen);
    wait_rsp("init_rd80", 0);
`else
    @(negedge CLK);
    chk("run_rdy_after_rst", req_rdy, 1);
    @(posedge CLK);
    #1;
`endif

    // Masked write over zeros, then a mask-0 write that must change nothing.
    do_req(1, 8'h3A, '0, 4'hF, wen);
    do_req(1, 8'h3A, {DW{1'b1}}, 4'b0101, wen);
    chk("masked_WEN", wen, WEN_05);
    do_req(0, 8'h3A, '0, 4'h0, wen);
    wait_rsp("masked_rd", MASKED);
    do_req(1, 8'h3A, {DW{1'b1}}, 4'h0, wen);
    chk("mask0_WEN", wen, {DW{1'b1}});
    do_req(0, 8'h3A, '0, 4'h0, wen);
    wait_rsp("mask0_rd", MASKED);

    // Streaming reads.
    for (int j = 0; j < 10; j++) do_req(1, AW'(j), pat(j), 4'hF, wen);
    for (int i = 0; i < 12; i++) begin
      req_vld  = (i < 10);
      req_wr   = 1'b0;
      req_addr = AW'(i);
      @(negedge CLK);
      if (i < 10) chk("stream_rdy", req_rdy, 1);
      if (i >= 2) begin
        chk("stream_vld", rsp_vld, 1);
        chk("stream_data", rsp_data, pat(i - 2));
      end
      @(posedge CLK);
      #1;
    end
    req_vld = 1'b0;

    // Back-pressure.
    rsp_rdy = 1'b0;
    nacc    = 0;
    for (int i = 0; i < 6; i++) begin
      req_vld  = 1'b1;
      req_addr = (nacc == 0) ? 8'd3 : 8'd7;
      @(negedge CLK);
      if (req_rdy) nacc++;
      @(posedge CLK);
      #1;
    end
    chk("bp_accepts", nacc, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_rdy_low", req_rdy, 0);
      chk("bp_hold", rsp_data, pat(3));
    end
    @(posedge CLK);
    #1;
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    @(negedge CLK);
    chk("bp_rdy_back", req_rdy, 1);
    chk("bp_drain0", rsp_data, pat(3));
    @(negedge CLK);
    chk("bp_drain1", rsp_data, pat(7));
    @(posedge CLK);
    #1;

    // Write-then-read hazard.
    do_req(1, 8'h10, X_VAL, 4'hF, wen);
    do_req(0, 8'h10, '0, 4'h0, wen);
    wait_rsp("hazard", X_VAL);

    // Reset with two responses buffered.
    rsp_rdy = 1'b0;
    do_req(0, 8'h10, '0, 4'h0, wen);
    do_req(0, 8'h3A, '0, 4'h0, wen);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("pre_rst_vld", rsp_vld, 1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("rst_mid_vld", rsp_vld, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST     = 1'b0;
    rsp_rdy = 1'b1;
`ifdef CT_F_SPSRAM_REQ_CTRL_INIT_EN
    repeat (100) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("rst_sweep_CEN", CEN, 1);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("sweep_restart_A", A, 0);
    wait_init();
    do_req(0, 8'h10, '0, 4'h0, wen);
    wait_rsp("post_rst_rd", 0);
`else
    do_req(0, 8'h10, '0, 4'h0, wen);
    wait_rsp("post_rst_rd", X_VAL);
`endif

    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
